// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: registers the ALU result and control bits,
// holds the architectural Z/N flags and resolves branches against them.
module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_z,
   input  logic              alu_n,
   input  logic              set_flags,
   input  logic [1:0]        br_type,
   input  logic [DATA_W-1:0] br_target,
   input  logic [REG_AW-1:0] rd,
   input  logic              reg_wr,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [DATA_W-1:0] store_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_res,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_wr,
   output logic              out_mem_rd,
   output logic              out_mem_wr,
   output logic [DATA_W-1:0] out_store_data,
   output logic              flag_z,
   output logic              flag_n,
   output logic              take_branch,
   output logic [DATA_W-1:0] branch_pc
);

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_JUMP = 2'b01;
   localparam logic [1:0] BR_Z    = 2'b10;
   localparam logic [1:0] BR_N    = 2'b11;

   logic              cap;
   logic              taken;

   logic              valid_q,   valid_d;
   logic [DATA_W-1:0] res_q,     res_d;
   logic [REG_AW-1:0] rd_q,      rd_d;
   logic              reg_wr_q,  reg_wr_d;
   logic              mem_rd_q,  mem_rd_d;
   logic              mem_wr_q,  mem_wr_d;
   logic [DATA_W-1:0] sdata_q,   sdata_d;
   logic              flag_z_q,  flag_z_d;
   logic              flag_n_q,  flag_n_d;
   logic              br_q,      br_d;
   logic [DATA_W-1:0] br_pc_q,   br_pc_d;

   // An instruction enters the stage only when presented, not held and not killed.
   assign cap = in_valid & ~stall & ~flush;

   // Branch decode against the flags as they stand before this instruction.
   always_comb begin
      taken = 1'b0;
      case (br_type)
         BR_NONE: taken = 1'b0;
         BR_JUMP: taken = 1'b1;
         BR_Z:    taken = flag_z_q;
         BR_N:    taken = flag_n_q;
         default: taken = 1'b0;
      endcase
   end

   // Next-state for the boundary registers, flags and redirect pulse.
   always_comb begin
      valid_d  = valid_q;
      res_d    = res_q;
      rd_d     = rd_q;
      reg_wr_d = reg_wr_q;
      mem_rd_d = mem_rd_q;
      mem_wr_d = mem_wr_q;
      sdata_d  = sdata_q;
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      br_d     = 1'b0;              // redirect is a single-cycle pulse, even under stall
      br_pc_d  = br_pc_q;
      if (!stall) begin
         if (cap) begin
            valid_d  = 1'b1;
            res_d    = alu_res;
            rd_d     = rd;
            reg_wr_d = reg_wr;
            mem_rd_d = mem_rd;
            mem_wr_d = mem_wr;
            sdata_d  = store_data;
            if (set_flags) begin
               flag_z_d = alu_z;
               flag_n_d = alu_n;
            end
            if (taken) begin
               br_d    = 1'b1;
               br_pc_d = br_target;
            end
         end else begin
            // Bubble or flush: data fields keep their last (defined) values.
            valid_d  = 1'b0;
            reg_wr_d = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
         end
      end
   end

   // State registers; reset overrides stall and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         res_q    <= '0;
         rd_q     <= '0;
         reg_wr_q <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         sdata_q  <= '0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
         br_q     <= 1'b0;
         br_pc_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         res_q    <= res_d;
         rd_q     <= rd_d;
         reg_wr_q <= reg_wr_d;
         mem_rd_q <= mem_rd_d;
         mem_wr_q <= mem_wr_d;
         sdata_q  <= sdata_d;
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
         br_q     <= br_d;
         br_pc_q  <= br_pc_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_res        = res_q;
   assign out_rd         = rd_q;
   assign out_reg_wr     = reg_wr_q;
   assign out_mem_rd     = mem_rd_q;
   assign out_mem_wr     = mem_wr_q;
   assign out_store_data = sdata_q;
   assign flag_z         = flag_z_q;
   assign flag_n         = flag_n_q;
   assign take_branch    = br_q;
   assign branch_pc      = br_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a random run
// compared against a behavioural model of the stage.
module tb_ex_mem_stage;
   localparam int DATA_W = 32;
   localparam int REG_AW = 6;

   logic              clk = 1'b0;
   logic              rst, in_valid, stall, flush;
   logic [DATA_W-1:0] alu_res, br_target, store_data;
   logic              alu_z, alu_n, set_flags, reg_wr, mem_rd, mem_wr;
   logic [1:0]        br_type;
   logic [REG_AW-1:0] rd;
   logic              out_valid, out_reg_wr, out_mem_rd, out_mem_wr;
   logic [DATA_W-1:0] out_res, out_store_data, branch_pc;
   logic [REG_AW-1:0] out_rd;
   logic              flag_z, flag_n, take_branch;

   int errors = 0;
   int checks = 0;

   ex_mem_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .alu_res(alu_res), .alu_z(alu_z), .alu_n(alu_n), .set_flags(set_flags),
      .br_type(br_type), .br_target(br_target), .rd(rd), .reg_wr(reg_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .store_data(store_data),
      .out_valid(out_valid), .out_res(out_res), .out_rd(out_rd),
      .out_reg_wr(out_reg_wr), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_store_data(out_store_data), .flag_z(flag_z), .flag_n(flag_n),
      .take_branch(take_branch), .branch_pc(branch_pc)
   );

   always #5 clk = ~clk;

   // Behavioural reference: what the stage should hold after each edge.
   logic              m_valid, m_reg_wr, m_mem_rd, m_mem_wr, m_fz, m_fn, m_tb;
   logic [DATA_W-1:0] m_res, m_sdata, m_bpc;
   logic [REG_AW-1:0] m_rd;
   always @(posedge clk) begin
      bit t;
      if (rst) begin
         m_valid = 0; m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0;
         m_fz = 0; m_fn = 0; m_tb = 0; m_res = 0; m_sdata = 0; m_bpc = 0; m_rd = 0;
      end else if (stall) begin
         m_tb = 0;
      end else if (in_valid && !flush) begin
         t = (br_type == 2'd1) || (br_type == 2'd2 && m_fz) || (br_type == 2'd3 && m_fn);
         m_tb = t;
         if (t) m_bpc = br_target;
         if (set_flags) begin m_fz = alu_z; m_fn = alu_n; end
         m_valid = 1; m_res = alu_res; m_rd = rd; m_sdata = store_data;
         m_reg_wr = reg_wr; m_mem_rd = mem_rd; m_mem_wr = mem_wr;
      end else begin
         m_tb = 0; m_valid = 0; m_reg_wr = 0; m_mem_rd = 0; m_mem_wr = 0;
      end
   end

   task automatic idle_inputs();
      rst = 0; in_valid = 0; stall = 0; flush = 0; alu_res = 0; alu_z = 0; alu_n = 0;
      set_flags = 0; br_type = 0; br_target = 0; rd = 0; reg_wr = 0; mem_rd = 0;
      mem_wr = 0; store_data = 0;
   endtask

   // Let one rising edge happen, then settle for sampling.
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(negedge clk); idle_inputs(); rst = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
         checks++; if ({flag_z, flag_n} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {flag_z, flag_n}); end
         checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL reset_take got=%b exp=0", take_branch); end
         checks++; if (branch_pc !== 32'h0) begin errors++; $display("FAIL reset_bpc got=%h exp=0", branch_pc); end
         checks++; if (out_res !== 32'h0 || out_rd !== 6'h0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0", out_res, out_rd); end
      end
      @(negedge clk); rst = 0;
   endtask

   task automatic test_flag_branch();
      @(negedge clk); idle_inputs(); in_valid = 1; alu_res = 0; alu_z = 1; set_flags = 1; reg_wr = 1; rd = 6'd3;
      tick();
      checks++; if (flag_z !== 1'b1) begin errors++; $display("FAIL fb_flag_z got=%b exp=1", flag_z); end
      checks++; if (out_valid !== 1'b1 || out_rd !== 6'd3) begin errors++; $display("FAIL fb_capture got=%b/%0d exp=1/3", out_valid, out_rd); end
      checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL fb_no_take got=%b exp=0", take_branch); end
      @(negedge clk); idle_inputs(); in_valid = 1; br_type = 2'b10; br_target = 32'h40;
      tick();
      checks++; if (take_branch !== 1'b1) begin errors++; $display("FAIL fb_take got=%b exp=1", take_branch); end
      checks++; if (branch_pc !== 32'h40) begin errors++; $display("FAIL fb_bpc got=%h exp=40", branch_pc); end
      @(negedge clk); idle_inputs();
      tick();
      checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL fb_pulse_end got=%b exp=0", take_branch); end
   endtask

   task automatic test_old_flag();
      @(negedge clk); idle_inputs(); in_valid = 1; set_flags = 1; alu_z = 0; alu_n = 1;
      tick();
      checks++; if ({flag_z, flag_n} !== 2'b01) begin errors++; $display("FAIL of_setup got=%b exp=01", {flag_z, flag_n}); end
      @(negedge clk); idle_inputs(); in_valid = 1; br_type = 2'b11; set_flags = 1; alu_n = 0; br_target = 32'h80;
      tick();
      checks++; if (take_branch !== 1'b1) begin errors++; $display("FAIL of_take got=%b exp=1", take_branch); end
      checks++; if (branch_pc !== 32'h80) begin errors++; $display("FAIL of_bpc got=%h exp=80", branch_pc); end
      checks++; if (flag_n !== 1'b0) begin errors++; $display("FAIL of_flag_n got=%b exp=0", flag_n); end
      // Back-to-back: the branch-if-N now sees the cleared flag.
      @(negedge clk); idle_inputs(); in_valid = 1; br_type = 2'b11; br_target = 32'h90;
      tick();
      checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL of_b2b got=%b exp=0", take_branch); end
   endtask

   task automatic test_stall();
      logic fz0, fn0;
      @(negedge clk); idle_inputs(); in_valid = 1; alu_res = 32'h1234; rd = 6'd5; reg_wr = 1; br_type = 2'b01; br_target = 32'h200;
      tick();
      fz0 = flag_z; fn0 = flag_n;
      checks++; if (take_branch !== 1'b1) begin errors++; $display("FAIL st_take got=%b exp=1", take_branch); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); stall = 1; in_valid = 1; alu_res = $urandom; rd = 6'($urandom);
         set_flags = 1; alu_z = ~fz0; alu_n = ~fn0; br_type = 2'b01; reg_wr = 0;
         tick();
         checks++; if (out_res !== 32'h1234 || out_rd !== 6'd5) begin errors++; $display("FAIL st_data got=%h/%0d exp=1234/5", out_res, out_rd); end
         checks++; if (out_valid !== 1'b1 || out_reg_wr !== 1'b1) begin errors++; $display("FAIL st_ctrl got=%b/%b exp=1/1", out_valid, out_reg_wr); end
         checks++; if (flag_z !== fz0 || flag_n !== fn0) begin errors++; $display("FAIL st_flags got=%b%b exp=%b%b", flag_z, flag_n, fz0, fn0); end
         checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL st_take_off got=%b exp=0", take_branch); end
      end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_flush();
      logic fz0;
      @(negedge clk); idle_inputs();
      tick();
      fz0 = flag_z;
      @(negedge clk); in_valid = 1; flush = 1; set_flags = 1; alu_z = ~fz0; br_type = 2'b01; reg_wr = 1; mem_wr = 1;
      tick();
      checks++; if (out_valid !== 1'b0 || out_reg_wr !== 1'b0 || out_mem_wr !== 1'b0) begin errors++; $display("FAIL fl_kill got=%b%b%b exp=000", out_valid, out_reg_wr, out_mem_wr); end
      checks++; if (flag_z !== fz0) begin errors++; $display("FAIL fl_flag got=%b exp=%b", flag_z, fz0); end
      checks++; if (take_branch !== 1'b0) begin errors++; $display("FAIL fl_take got=%b exp=0", take_branch); end
      // Capture a valid load, then flush+stall: the stage must hold it.
      @(negedge clk); idle_inputs(); in_valid = 1; mem_rd = 1; alu_res = 32'hABCD; rd = 6'd9;
      tick();
      @(negedge clk); flush = 1; stall = 1; alu_res = 32'h5555; mem_rd = 0; set_flags = 1; alu_z = ~flag_z; br_type = 2'b01;
      fz0 = flag_z;
      tick();
      checks++; if (out_valid !== 1'b1 || out_mem_rd !== 1'b1 || out_res !== 32'hABCD) begin errors++; $display("FAIL fl_stall_hold got=%b/%b/%h exp=1/1/abcd", out_valid, out_mem_rd, out_res); end
      checks++; if (flag_z !== fz0 || take_branch !== 1'b0) begin errors++; $display("FAIL fl_stall_flags got=%b/%b exp=%b/0", flag_z, take_branch, fz0); end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk); idle_inputs(); in_valid = 1; set_flags = 1; alu_z = 1; alu_n = 1; br_type = 2'b01;
      br_target = 32'hF0; reg_wr = 1; alu_res = 32'h77;
      tick();
      checks++; if (take_branch !== 1'b1 || flag_z !== 1'b1) begin errors++; $display("FAIL rm_setup got=%b/%b exp=1/1", take_branch, flag_z); end
      @(negedge clk); rst = 1; stall = 1;
      tick();
      checks++; if ({out_valid, out_reg_wr, take_branch, flag_z, flag_n} !== 5'b0) begin errors++; $display("FAIL rm_bits got=%b exp=00000", {out_valid, out_reg_wr, take_branch, flag_z, flag_n}); end
      checks++; if (out_res !== 32'h0 || branch_pc !== 32'h0) begin errors++; $display("FAIL rm_data got=%h/%h exp=0/0", out_res, branch_pc); end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 39) == 0);
         in_valid = ($urandom_range(0, 3) != 0); stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 5) == 0); alu_res = $urandom; alu_z = $urandom;
         alu_n = $urandom; set_flags = $urandom; br_type = 2'($urandom); br_target = $urandom;
         rd = 6'($urandom); reg_wr = $urandom; mem_rd = $urandom; mem_wr = $urandom; store_data = $urandom;
         tick();
         checks++;
         if (out_valid !== m_valid || {out_reg_wr, out_mem_rd, out_mem_wr} !== {m_reg_wr, m_mem_rd, m_mem_wr}) begin
            errors++; $display("FAIL rnd_ctrl i=%0d got=%b%b%b%b exp=%b%b%b%b", i, out_valid, out_reg_wr, out_mem_rd, out_mem_wr, m_valid, m_reg_wr, m_mem_rd, m_mem_wr);
         end
         checks++;
         if (flag_z !== m_fz || flag_n !== m_fn || take_branch !== m_tb) begin
            errors++; $display("FAIL rnd_flags i=%0d got=%b%b%b exp=%b%b%b", i, flag_z, flag_n, take_branch, m_fz, m_fn, m_tb);
         end
         if (m_valid) begin
            checks++;
            if (out_res !== m_res || out_rd !== m_rd || out_store_data !== m_sdata) begin
               errors++; $display("FAIL rnd_data i=%0d got=%h/%h/%h exp=%h/%h/%h", i, out_res, out_rd, out_store_data, m_res, m_rd, m_sdata);
            end
         end
         if (m_tb) begin
            checks++;
            if (branch_pc !== m_bpc) begin errors++; $display("FAIL rnd_bpc i=%0d got=%h exp=%h", i, branch_pc, m_bpc); end
         end
      end
      @(negedge clk); idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_flag_branch();
      test_old_flag();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Registers the ALU result and control bits into the EX/MEM boundary and holds the architectural Z/N condition flags.
- Resolves conditional and unconditional branches against those flags, then drives a one-cycle redirect to fetch and the memory stage.
- Supports stall (hold) and flush (kill) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width of result, store data and branch target
- REG_AW, 6, destination register index width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  an instruction is presented from EX this cycle
- stall  in  1  hold all stage state, ignore inputs
- flush  in  1  kill the instruction presented this cycle
- alu_res  in  DATA_W  ALU result
- alu_z  in  1  ALU zero flag (result == 0)
- alu_n  in  1  ALU negative flag (result MSB)
- set_flags  in  1  instruction updates Z/N (add, sub, neg)
- br_type  in  2  00 none, 01 jump, 10 branch-if-Z, 11 branch-if-N
- br_target  in  DATA_W  branch/jump destination address
- rd  in  REG_AW  destination register
- reg_wr  in  1  writes register file
- mem_rd  in  1  load
- mem_wr  in  1  store
- store_data  in  DATA_W  data for store
- out_valid  out  1  registered instruction valid toward MEM
- out_res  out  DATA_W  registered ALU result / memory address
- out_rd  out  REG_AW  registered destination
- out_reg_wr, out_mem_rd, out_mem_wr  out  1 each  registered controls, gated by out_valid
- out_store_data  out  DATA_W  registered store data
- flag_z, flag_n  out  1 each  architectural flag register
- take_branch  out  1  one-cycle redirect pulse
- branch_pc  out  DATA_W  redirect address, meaningful only when take_branch = 1

Behaviour:
- Reset (rst=1 at edge): all outputs 0, including flag_z, flag_n and branch_pc. rst has priority over stall and flush.
- Capture condition `cap = in_valid & ~stall & ~flush`.
- Latency: 1 cycle. The instruction captured at edge k is visible on out_* after edge k.
- On cap:
  - load all out_* from inputs; out_valid = 1
  - out_reg_wr, out_mem_rd and out_mem_wr are written as input & 1, i.e. copied directly.
- If ~stall and ~cap (bubble or flush): out_valid = 0 and out_reg_wr, out_mem_rd, out_mem_wr = 0. Data fields are don't-care but must not be X after reset.
- If stall and ~rst: every out_* register and both flags hold. take_branch = 0.
- Flag register:
  - on cap with set_flags = 1: flag_z <= alu_z, flag_n <= alu_n
  - otherwise flags hold
  - flushed or stalled instructions never modify the flags
- Branch resolution on cap, using flags as they stand BEFORE this instruction's own update:
  - br_type 01: taken
  - br_type 10: taken if flag_z
  - br_type 11: taken if flag_n
  - br_type 00: not taken
- On taken: take_branch = 1 and branch_pc <= br_target for exactly the next cycle. take_branch deasserts the following cycle regardless of stall.
- A branch with set_flags = 1 tests the old flags and then updates them.
- Back-to-back: a flag-setting op at edge k followed by a branch at edge k+1 sees the updated flags. No forwarding from alu_z/alu_n is performed.
- flush and stall asserted together: stall wins. The stage holds and the presented instruction is not captured; the hazard unit re-presents it.
- The block does not flush itself on take_branch. Killing younger instructions is the hazard unit's job via flush.
- Width rule: all fields are straight register copies. No arithmetic is performed in this block except the 2-bit branch decode.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0. Expect out_valid=0, flag_z=0, flag_n=0, take_branch=0 every cycle.
- Flag update + branch:
  - cycle 1: alu_res=0, alu_z=1, set_flags=1. Expect flag_z=1 after the edge.
  - cycle 2: br_type=10, br_target=0x40. Expect take_branch=1 and branch_pc=0x40 for exactly one cycle.
- Old-flag rule: flags z=0, n=1; present br_type=11, set_flags=1, alu_n=0, br_target=0x80. Expect take_branch=1 (old n used), then flag_n=0.
- Stall hold: capture alu_res=0x1234, rd=5, reg_wr=1. Assert stall 3 cycles while changing inputs. Expect out_res=0x1234, out_rd=5, out_valid=1 held, flags unchanged.
- Flush: in_valid=1, flush=1, set_flags=1, alu_z=1, br_type=01. Expect out_valid=0, out_reg_wr=0, flag_z unchanged, take_branch=0. Repeat with stall=1 as well: expect hold instead.
- Reset mid-stream: assert rst while stall=1 with a branch pending. Expect all outputs 0 next cycle, including take_branch and flags.
